// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame constants
// used by the receiver, transmitter and baud generator.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Receiver output bundle: byte, valid strobe, framing error, busy.
// The receiver drives the master side, the consumer reads the slave side.
interface uart_rx_oversampled_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 framing_error;
  logic                 busy;

  modport master (
    output rx_data,
    output rx_valid,
    output framing_error,
    output busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input framing_error,
    input busy
  );

endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous input;
// both flops reset to RESET_VAL so the output is defined at reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 oversampled UART receiver: mid-bit sampling, stop-bit check,
// one-cycle valid / framing-error strobes, single error per break.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic rx,
  uart_rx_oversampled_if.master rx_bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BT = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  uart_rx_state_t       state, state_nxt;
  logic [TW-1:0]        tick_cnt, tick_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 valid_q, valid_nxt;
  logic                 fe_q, fe_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      data_q   <= data_nxt;
      valid_q  <= valid_nxt;
      fe_q     <= fe_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    fe_nxt    = 1'b0;
    if (sample_tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            tick_nxt  = '0;
          end
        end
        START: begin
          tick_nxt = tick_cnt + 1'b1;
          if (tick_cnt == HALF_M1) begin
            if (rx_s) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = DATA;
              tick_nxt  = '0;
              bit_nxt   = '0;
            end
          end
        end
        DATA: begin
          tick_nxt = tick_cnt + 1'b1;
          if (tick_cnt == LAST_TK) begin
            tick_nxt  = '0;
            shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
            bit_nxt   = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BT)
              state_nxt = STOP;
          end
        end
        STOP: begin
          tick_nxt = tick_cnt + 1'b1;
          if (tick_cnt == LAST_TK) begin
            tick_nxt = '0;
            if (rx_s) begin
              data_nxt  = shreg;
              valid_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              fe_nxt    = 1'b1;
              state_nxt = BREAK_WAIT;
            end
          end
        end
        BREAK_WAIT: begin
          // Only a high line re-arms start detection, so a break
          // yields one framing error rather than a stream of frames.
          if (rx_s)
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign rx_bus.rx_data       = data_q;
  assign rx_bus.rx_valid      = valid_q;
  assign rx_bus.framing_error = fe_q;
  assign rx_bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: random and directed 8N1
// frames, glitch, break, reset abort and baud drift.
module tb_uart_rx_oversampled;

  localparam int OS       = uart_pkg::UART_OVERSAMPLE;
  localparam int DB       = uart_pkg::UART_DATA_BITS;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;

  typedef struct {
    bit         fe;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_tick = 1'b0;
  logic rx = 1'b1;

  uart_rx_oversampled_if #(.DATA_BITS(DB)) bus ();

  uart_rx_oversampled #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx),
    .rx_bus      (bus)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail = 0;
  longint tick_num = 0;
  ev_t    sb[$];
  longint valid_ticks[$];
  logic [7:0] exp_data = 8'h00;
  int     n_valid = 0;
  int     n_fe = 0;
  logic   prev_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin : tick_gen
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      sample_tick = (c == TICK_DIV - 1);
      if (sample_tick) tick_num++;
      c = (c + 1) % TICK_DIV;
    end
  end

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      check("valid_fe_exclusive",
            32'(bus.rx_valid & bus.framing_error), 0);
      if (bus.rx_valid || bus.framing_error) begin
        if (bus.rx_valid) n_valid++;
        if (bus.framing_error) n_fe++;
        if (sb.size() == 0) begin
          check("unexpected_output",
                32'({bus.rx_valid, bus.framing_error}), 0);
        end else begin
          e = sb.pop_front();
          check("out_kind_fe", 32'(bus.framing_error), 32'(e.fe));
          if (!e.fe) begin
            exp_data = e.data;
            check("rx_data", 32'(bus.rx_data), 32'(e.data));
            check("busy_falls_with_valid", 32'(bus.busy), 0);
            check("busy_before_valid", 32'(prev_busy), 1);
            valid_ticks.push_back(tick_num);
          end else begin
            check("busy_on_fe", 32'(bus.busy), 1);
          end
        end
      end
      prev_busy = bus.busy;
    end
  end

  task automatic line(input logic v, input int clks);
    rx = v;
    repeat (clks) @(posedge clk);
    #1;
  endtask

  // Model: a frame with a high stop bit delivers its byte, else one error.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int bclk);
    sb.push_back('{fe: !stop, data: d});
    line(1'b0, bclk);
    for (int i = 0; i < DB; i++) line(d[i], bclk);
    line(stop, bclk);
  endtask

  task automatic wait_drain(input int max_clks);
    int k;
    k = 0;
    while (sb.size() != 0 && k < max_clks) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_pending", 32'(sb.size()), 0);
  endtask

  initial begin : stim
    int v0, f0, nv, gap, bclk;
    logic [7:0] d;
    logic stop;
    logic [7:0] c3;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_rx_data", 32'(bus.rx_data), 0);
    check("reset_rx_valid", 32'(bus.rx_valid), 0);
    check("reset_fe", 32'(bus.framing_error), 0);
    check("reset_busy", 32'(bus.busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    line(1'b1, 2 * BIT_CLKS);

    send_frame(8'hA5, 1'b1, BIT_CLKS);
    line(1'b1, 2 * BIT_CLKS);
    wait_drain(20 * BIT_CLKS);
    check("single_valid_count", 32'(n_valid), 1);
    check("single_fe_count", 32'(n_fe), 0);
    check("single_rx_data", 32'(bus.rx_data), 32'h A5);

    send_frame(8'h00, 1'b1, BIT_CLKS);
    send_frame(8'hFF, 1'b1, BIT_CLKS);
    send_frame(8'h3C, 1'b1, BIT_CLKS);
    line(1'b1, 2 * BIT_CLKS);
    wait_drain(40 * BIT_CLKS);
    check("b2b_valid_count", 32'(n_valid), 4);
    nv = valid_ticks.size();
    if (nv >= 3) begin
      check("b2b_spacing_1",
            32'(valid_ticks[nv-2] - valid_ticks[nv-3]), 160);
      check("b2b_spacing_2",
            32'(valid_ticks[nv-1] - valid_ticks[nv-2]), 160);
    end else begin
      check("b2b_valid_ticks", 32'(nv), 3);
    end
    check("b2b_rx_data", 32'(bus.rx_data), 32'h3C);

    v0 = n_valid;
    f0 = n_fe;
    line(1'b0, 5 * TICK_DIV);
    check("glitch_busy_high", 32'(bus.busy), 1);
    line(1'b1, 12 * TICK_DIV);
    check("glitch_busy_low", 32'(bus.busy), 0);
    check("glitch_no_valid", 32'(n_valid), 32'(v0));
    check("glitch_no_fe", 32'(n_fe), 32'(f0));
    check("glitch_rx_data", 32'(bus.rx_data), 32'(exp_data));
    line(1'b1, BIT_CLKS);

    f0 = n_fe;
    v0 = n_valid;
    send_frame(8'h55, 1'b0, BIT_CLKS);
    line(1'b0, 30 * BIT_CLKS);
    check("break_one_fe", 32'(n_fe), 32'(f0 + 1));
    check("break_no_valid", 32'(n_valid), 32'(v0));
    check("break_busy_held", 32'(bus.busy), 1);
    check("break_rx_data_kept", 32'(bus.rx_data), 32'h3C);
    line(1'b1, 2 * BIT_CLKS);
    check("break_busy_released", 32'(bus.busy), 0);
    send_frame(8'h12, 1'b1, BIT_CLKS);
    line(1'b1, 2 * BIT_CLKS);
    wait_drain(20 * BIT_CLKS);
    check("after_break_rx_data", 32'(bus.rx_data), 32'h12);

    c3 = 8'hC3;
    line(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) line(c3[i], BIT_CLKS);
    line(c3[3], BIT_CLKS / 2);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_rx_data", 32'(bus.rx_data), 0);
    check("rst_mid_rx_valid", 32'(bus.rx_valid), 0);
    check("rst_mid_fe", 32'(bus.framing_error), 0);
    check("rst_mid_busy", 32'(bus.busy), 0);
    sb.delete();
    exp_data = 8'h00;
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    line(1'b1, 2 * BIT_CLKS);
    send_frame(8'h81, 1'b1, BIT_CLKS);
    line(1'b1, 2 * BIT_CLKS);
    wait_drain(20 * BIT_CLKS);
    check("after_reset_rx_data", 32'(bus.rx_data), 32'h81);

    v0 = n_valid;
    send_frame(8'h96, 1'b1, 66);
    line(1'b1, 2 * BIT_CLKS);
    wait_drain(20 * BIT_CLKS);
    check("drift_fast_valid", 32'(n_valid), 32'(v0 + 1));
    check("drift_fast_data", 32'(bus.rx_data), 32'h96);
    send_frame(8'h96, 1'b1, 62);
    line(1'b1, 2 * BIT_CLKS);
    wait_drain(20 * BIT_CLKS);
    check("drift_slow_valid", 32'(n_valid), 32'(v0 + 2));
    check("drift_slow_data", 32'(bus.rx_data), 32'h96);

    for (int n = 0; n < 16; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      bclk = BIT_CLKS - 1 + int'($urandom_range(2));
      gap  = stop ? int'($urandom_range(2)) : 1 + int'($urandom_range(1));
      send_frame(d, stop, bclk);
      if (gap > 0) line(1'b1, gap * bclk);
    end
    line(1'b1, 2 * BIT_CLKS);
    wait_drain(40 * BIT_CLKS);
    check("random_final_rx_data", 32'(bus.rx_data), 32'(exp_data));
    check("final_busy", 32'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
